// File: rtl/zap_stage_fifo.sv
// Pipeline stage FIFO: FWFT circular buffer feeding a registered output, with
// prioritised per-level clear/stall control.
module zap_stage_fifo #(
  parameter int WDT       = 32,
  parameter int DEPTH     = 8,
  parameter int NUM_CTL   = 4,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_CTL-1:0]         i_ctl_clear,
  input  logic [NUM_CTL-1:0]         i_ctl_stall,
  input  logic                       i_write_inhibit,
  input  logic                       i_valid,
  input  logic [WDT-1:0]             i_instr,
  output logic [WDT-1:0]             o_instr,
  output logic                       o_valid,
  output logic                       o_full,
  output logic                       o_afull,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {ACT_RUN, ACT_STALL, ACT_CLEAR} action_t;

  action_t        action;
  logic           found;
  logic [WDT-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           wr_req, push, pop;

  // First set level decides; clear beats stall only within the same level.
  always_comb begin
    action = ACT_RUN;
    found  = 1'b0;
    for (int k = 0; k < NUM_CTL; k++) begin
      if (!found && (i_ctl_clear[k] || i_ctl_stall[k])) begin
        found  = 1'b1;
        action = i_ctl_clear[k] ? ACT_CLEAR : ACT_STALL;
      end
    end
  end

  assign o_full  = (o_count == CW'(DEPTH));
  assign o_afull = (o_count >= CW'(AFULL_LVL));
  assign wr_req  = i_valid && !i_write_inhibit;
  assign push    = wr_req && !o_full && (action != ACT_CLEAR) && !i_reset;
  assign pop     = (action == ACT_RUN) && (o_count != '0);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_instr;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
      o_valid <= 1'b0;
      o_instr <= '0;
      o_drop  <= 1'b0;
    end else begin
      // A write that loses to a full buffer is reported; one lost to a flush is not.
      o_drop <= wr_req && o_full && (action != ACT_CLEAR);
      if (action == ACT_CLEAR) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        o_count <= '0;
        o_valid <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      o_count <= o_count + CW'(1);
        else if (pop && !push) o_count <= o_count - CW'(1);
        if (action == ACT_RUN) begin
          o_valid <= (o_count != '0);
          if (o_count != '0) o_instr <= mem[rd_ptr];
        end
      end
    end
  end
endmodule

// File: tb/tb_zap_stage_fifo.sv
// Directed bench for zap_stage_fifo: latency, stall/full, priority, wrap, reset.
module tb_zap_stage_fifo;
  localparam int WDT = 32, DEPTH = 8, NUM_CTL = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     clr, stl;
  logic           inh, vld;
  logic [WDT-1:0] din;
  logic [WDT-1:0] o_instr;
  logic           o_valid, o_full, o_afull, o_drop;
  logic [3:0]     o_count;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  zap_stage_fifo #(.WDT(WDT), .DEPTH(DEPTH), .NUM_CTL(NUM_CTL)) dut (
    .i_clk(clk), .i_reset(rst), .i_ctl_clear(clr), .i_ctl_stall(stl),
    .i_write_inhibit(inh), .i_valid(vld), .i_instr(din),
    .o_instr(o_instr), .o_valid(o_valid), .o_full(o_full), .o_afull(o_afull),
    .o_count(o_count), .o_drop(o_drop)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1; clr = 0; stl = 0; inh = 0; vld = 0; din = 0;
    tick; tick;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", o_valid); end
    checks++; if (o_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", o_instr); end
    checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", o_count); end
    checks++; if ({o_full, o_afull, o_drop} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {o_full, o_afull, o_drop}); end
    rst = 0;
  endtask

  task automatic test_latency;
    logic [WDT-1:0] exp_d [3] = '{32'hA1, 32'hA2, 32'hA3};
    vld = 1; din = 32'hA1; tick;
    checks++; if (o_valid !== 1'b0 || o_count !== 4'd1) begin errors++; $display("FAIL lat_first got v=%b c=%0d exp v=0 c=1", o_valid, o_count); end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) din = exp_d[i+1]; else vld = 0;
      tick;
      checks++; if (o_valid !== 1'b1 || o_instr !== exp_d[i]) begin errors++; $display("FAIL lat_out%0d got v=%b d=%h exp v=1 d=%h", i, o_valid, o_instr, exp_d[i]); end
    end
    tick;
    checks++; if (o_valid !== 1'b0 || o_instr !== 32'hA3 || o_count !== 4'd0) begin errors++; $display("FAIL lat_end got v=%b d=%h c=%0d exp v=0 d=a3 c=0", o_valid, o_instr, o_count); end
  endtask

  task automatic test_inhibit;
    vld = 1; inh = 1; din = 32'hEE; tick;
    checks++; if (o_count !== 4'd0 || o_drop !== 1'b0) begin errors++; $display("FAIL inhibit got c=%0d drop=%b exp c=0 drop=0", o_count, o_drop); end
    vld = 0; inh = 0;
  endtask

  task automatic test_stall_full;
    stl = 4'b0001; vld = 1;
    for (int k = 1; k <= 9; k++) begin
      din = 32'h100 + k; tick;
      checks++; if (o_count !== 4'((k > 8) ? 8 : k)) begin errors++; $display("FAIL full_count%0d got %0d exp %0d", k, o_count, (k > 8) ? 8 : k); end
      checks++; if (o_afull !== (k >= 6) || o_full !== (k >= 8)) begin errors++; $display("FAIL full_flags%0d got af=%b f=%b exp af=%b f=%b", k, o_afull, o_full, k >= 6, k >= 8); end
      checks++; if (o_drop !== (k == 9)) begin errors++; $display("FAIL full_drop%0d got %b exp %b", k, o_drop, k == 9); end
    end
    vld = 0; tick;
    checks++; if (o_drop !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL full_after got drop=%b v=%b exp 0 0", o_drop, o_valid); end
    // Write during a flush while full must vanish silently.
    vld = 1; stl = 0; clr = 4'b0001; tick;
    checks++; if (o_count !== 4'd0 || o_drop !== 1'b0 || o_full !== 1'b0) begin errors++; $display("FAIL clr_full got c=%0d drop=%b f=%b exp 0 0 0", o_count, o_drop, o_full); end
    vld = 0; clr = 0;
  endtask

  task automatic test_priority;
    stl = 4'b0001; vld = 1;
    for (int k = 0; k < 5; k++) begin din = 32'hB0 + k; tick; end
    vld = 0; stl = 0; tick;
    checks++; if (o_count !== 4'd4 || o_valid !== 1'b1 || o_instr !== 32'hB0) begin errors++; $display("FAIL pri_setup got c=%0d v=%b d=%h exp 4 1 b0", o_count, o_valid, o_instr); end
    stl = 4'b0010; clr = 4'b0100; tick;
    checks++; if (o_count !== 4'd4 || o_valid !== 1'b1 || o_instr !== 32'hB0) begin errors++; $display("FAIL pri_stall got c=%0d v=%b d=%h exp 4 1 b0", o_count, o_valid, o_instr); end
    stl = 0; vld = 1; din = 32'hBF; tick;
    checks++; if (o_count !== 4'd0 || o_valid !== 1'b0 || o_instr !== 32'hB0 || o_drop !== 1'b0) begin errors++; $display("FAIL pri_clear got c=%0d v=%b d=%h drop=%b exp 0 0 b0 0", o_count, o_valid, o_instr, o_drop); end
    clr = 0; vld = 0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 22; i++) begin
      vld = (i < 20); din = 32'hC00 + i; tick;
      checks++; if (o_valid !== (i >= 1 && i <= 20)) begin errors++; $display("FAIL b2b_valid%0d got %b exp %b", i, o_valid, i >= 1 && i <= 20); end
      if (i >= 1 && i <= 20) begin
        checks++; if (o_instr !== 32'hC00 + i - 1) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", i, o_instr, 32'hC00 + i - 1); end
      end
      checks++; if (o_count !== 4'((i < 20) ? 1 : 0) || o_drop !== 1'b0) begin errors++; $display("FAIL b2b_cnt%0d got c=%0d drop=%b exp c=%0d drop=0", i, o_count, o_drop, (i < 20) ? 1 : 0); end
    end
  endtask

  task automatic test_reset_mid;
    stl = 4'b0001; vld = 1;
    for (int k = 0; k < 8; k++) begin din = 32'hD00 + k; tick; end
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL mid_full got %b exp 1", o_full); end
    din = 32'hDFF; rst = 1; tick;
    checks++; if ({o_valid, o_full, o_afull, o_drop} !== 4'b0000 || o_count !== 4'd0 || o_instr !== 32'h0) begin errors++; $display("FAIL mid_rst got v=%b f=%b af=%b drop=%b c=%0d d=%h exp all 0", o_valid, o_full, o_afull, o_drop, o_count, o_instr); end
    rst = 0; stl = 0; din = 32'hD1; tick;
    checks++; if (o_count !== 4'd1) begin errors++; $display("FAIL mid_push got c=%0d exp 1", o_count); end
    vld = 0; tick;
    checks++; if (o_valid !== 1'b1 || o_instr !== 32'hD1) begin errors++; $display("FAIL mid_first got v=%b d=%h exp 1 d1", o_valid, o_instr); end
    tick;
    checks++; if (o_valid !== 1'b0 || o_count !== 4'd0) begin errors++; $display("FAIL mid_drain got v=%b c=%0d exp 0 0", o_valid, o_count); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_inhibit;
    test_stall_full;
    test_priority;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
